// File: rtl/systolic_skew_feeder_pkg.sv
// systolic_skew_feeder_pkg: shared widths, FSM state and element vector type for the skew feeder
package systolic_skew_feeder_pkg;
  localparam int BITS_AB_DEF = 8;
  localparam int DIM_DEF = 8;
  typedef enum logic {IDLE, STREAM} state_t;
  typedef logic signed [BITS_AB_DEF-1:0] elem_vec_t [DIM_DEF];
endpackage

// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: matrix load, start and skewed wavefront output bundle
interface systolic_skew_feeder_if #(
  parameter int BITS_AB = systolic_skew_feeder_pkg::BITS_AB_DEF,
  parameter int DIM = systolic_skew_feeder_pkg::DIM_DEF
);
  logic wr_en;
  logic [$clog2(DIM)-1:0] wr_row;
  logic signed [BITS_AB-1:0] wr_data [DIM];
  logic start;
  logic busy;
  logic out_valid;
  logic signed [BITS_AB-1:0] out_data [DIM];
  logic done;
  modport master (output wr_en, wr_row, wr_data, start, input busy, out_valid, out_data, done);
  modport slave (input wr_en, wr_row, wr_data, start, output busy, out_valid, out_data, done);
endinterface

// File: rtl/systolic_skew_feeder_lane.sv
// systolic_skew_lane: picks element t-R of this lane's source vector, zero outside the diagonal window
module systolic_skew_lane #(
  parameter int BITS_AB = 8,
  parameter int DIM = 8,
  parameter int R = 0,
  parameter int CW = $clog2(2*DIM)
) (
  input  logic [CW-1:0] t,
  input  logic signed [BITS_AB-1:0] src [DIM],
  output logic signed [BITS_AB-1:0] val
);
  localparam int AW = $clog2(DIM);
  logic [CW-1:0] k;
  logic in_rng;
  always_comb begin
    k = t - CW'(R);
    in_rng = t >= CW'(R) && k < CW'(DIM);
    val = in_rng ? src[k[AW-1:0]] : '0;
  end
endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers a DIM x DIM matrix and streams it as a diagonal wavefront, lane r delayed r steps
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEF,
  parameter int DIM = DIM_DEF,
  parameter bit TRANSPOSE = 1'b0
) (
  input logic clk,
  input logic rst_n,
  input logic en,
  systolic_skew_feeder_if.slave bus
);
  localparam int CW = $clog2(2*DIM);
  localparam logic [CW-1:0] T_LAST = CW'(2*DIM-1);
  state_t state_q, state_d;
  logic [CW-1:0] t_q, t_d;
  logic signed [BITS_AB-1:0] m_q [DIM][DIM];
  logic signed [BITS_AB-1:0] m_d [DIM][DIM];
  logic signed [BITS_AB-1:0] lane_src [DIM][DIM];
  logic signed [BITS_AB-1:0] step_val [DIM];
  logic signed [BITS_AB-1:0] out_data_q [DIM];
  logic signed [BITS_AB-1:0] out_data_d [DIM];
  logic out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
  logic go, fin, adv;
  // the B side reads columns, so each lane sees its column as a flat vector
  always_comb begin
    for (int r = 0; r < DIM; r++)
      for (int i = 0; i < DIM; i++)
        lane_src[r][i] = TRANSPOSE ? m_q[i][r] : m_q[r][i];
  end
  for (genvar r = 0; r < DIM; r++) begin : g_lane
    systolic_skew_lane #(.BITS_AB(BITS_AB), .DIM(DIM), .R(r), .CW(CW)) u_lane (
      .t(t_q),
      .src(lane_src[r]),
      .val(step_val[r])
    );
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q <= '0;
      m_q <= '{default: '0};
      out_data_q <= '{default: '0};
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      m_q <= m_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    go = state_q == IDLE && bus.start && !bus.wr_en;
    fin = state_q == STREAM && en && t_q == T_LAST;
    state_d = go ? STREAM : fin ? IDLE : state_q;
  end
  // t_q is 0 in IDLE, so the lanes already present step 0 when start is accepted
  always_comb begin
    adv = state_q == STREAM && en && !fin;
    m_d = m_q;
    if (state_q == IDLE && bus.wr_en) m_d[bus.wr_row] = bus.wr_data;
    t_d = fin ? '0 : (go || adv) ? t_q + 1'b1 : t_q;
    out_data_d = out_data_q;
    if (fin) out_data_d = '{default: '0};
    else if (go || adv) out_data_d = step_val;
    out_valid_d = go ? 1'b1 : fin ? 1'b0 : out_valid_q;
    busy_d = go ? 1'b1 : fin ? 1'b0 : busy_q;
    done_d = fin;
  end
  assign bus.out_data = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed table checks of A and B wavefronts plus stall, ignore and reset sequences
module tb_systolic_skew_feeder;
  import systolic_skew_feeder_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic en = 1;
  int checks = 0;
  int failures = 0;
  int cap_a [15][8];
  int cap_b [15][8];
  int vcyc, dcyc;
  typedef struct {int step; int lane; bit tr; int exp;} vec_t;
  vec_t tbl [20];
  systolic_skew_feeder_if #(.BITS_AB(8), .DIM(8)) ifa ();
  systolic_skew_feeder_if #(.BITS_AB(8), .DIM(8)) ifb ();
  assign ifb.wr_en = ifa.wr_en;
  assign ifb.wr_row = ifa.wr_row;
  assign ifb.wr_data = ifa.wr_data;
  assign ifb.start = ifa.start;
  systolic_skew_feeder #(.BITS_AB(8), .DIM(8), .TRANSPOSE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(ifa.slave));
  systolic_skew_feeder #(.BITS_AB(8), .DIM(8), .TRANSPOSE(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(ifb.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic load_row(input int r, input elem_vec_t d);
    ifa.wr_en = 1;
    ifa.wr_row = 3'(r);
    ifa.wr_data = d;
    @(posedge clk);
    #1 ifa.wr_en = 0;
  endtask

  task automatic load_pattern();
    elem_vec_t d;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) d[c] = 8'(8*r + c + 1);
      load_row(r, d);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    int nz = 0;
    for (int l = 0; l < 8; l++) nz += (ifa.out_data[l] != 0) + (ifb.out_data[l] != 0);
    chk({tag, "_data_nonzero"}, nz, 0);
    chk({tag, "_valid"}, int'(ifa.out_valid) + int'(ifb.out_valid), 0);
    chk({tag, "_busy"}, int'(ifa.busy) + int'(ifb.busy), 0);
    chk({tag, "_done"}, int'(ifa.done) + int'(ifb.done), 0);
  endtask

  task automatic run_stream(input int stall_step, input int stall_len, input int wr_step,
                            output int vc, output int dc);
    int s = 0, stalled = 0, cyc = 0, ok;
    bit held = 0, fin = 0;
    elem_vec_t junk;
    foreach (junk[i]) junk[i] = 8'sd99;
    for (int i = 0; i < 15; i++)
      for (int l = 0; l < 8; l++) begin
        cap_a[i][l] = -999;
        cap_b[i][l] = -999;
      end
    vc = 0;
    dc = -1;
    ifa.start = 1;
    @(posedge clk);
    #1 ifa.start = 0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      en = 1;
      ifa.wr_en = 0;
      if (ifa.done) begin
        dc = cyc;
        fin = 1;
        chk("done_valid_low", int'(ifa.out_valid) + int'(ifb.out_valid), 0);
        chk("done_busy_low", int'(ifa.busy) + int'(ifb.busy), 0);
        chk("done_b_aligned", int'(ifb.done), 1);
      end else if (ifa.out_valid || held) begin
        if (ifa.out_valid) vc++;
        if (held) begin
          ok = int'(ifa.out_valid);
          for (int l = 0; l < 8; l++)
            if (int'(ifa.out_data[l]) != cap_a[s][l] || int'(ifb.out_data[l]) != cap_b[s][l]) ok = 0;
          chk("stall_hold", ok, 1);
        end else if (s < 15) begin
          for (int l = 0; l < 8; l++) begin
            cap_a[s][l] = int'(ifa.out_data[l]);
            cap_b[s][l] = int'(ifb.out_data[l]);
          end
        end
        if (s == wr_step && !held) begin
          ifa.wr_en = 1;
          ifa.wr_row = 3'd0;
          ifa.wr_data = junk;
        end
        if (s == stall_step && stalled < stall_len) begin
          en = 0;
          stalled++;
          held = 1;
        end else begin
          held = 0;
          s++;
        end
      end
    end
    en = 1;
    ifa.wr_en = 0;
    if (!fin) chk("done_timeout", 0, 1);
    else begin
      @(negedge clk);
      chk("done_one_cycle", int'(ifa.done) + int'(ifb.done), 0);
    end
  endtask

  task automatic check_table(input string tag);
    int act;
    foreach (tbl[i]) begin
      act = tbl[i].tr ? cap_b[tbl[i].step][tbl[i].lane] : cap_a[tbl[i].step][tbl[i].lane];
      chk($sformatf("%s_%s_s%0d_l%0d", tag, tbl[i].tr ? "B" : "A", tbl[i].step, tbl[i].lane),
          act, tbl[i].exp);
    end
  endtask

  initial begin
    elem_vec_t d;
    int nz;
    // M[r][c] = 8r+c+1: A lane r at step t is 7r+t+1, B lane r is 8t-7r+1
    tbl = '{'{0,0,0,1}, '{0,1,0,0}, '{3,2,0,18}, '{7,0,0,8}, '{7,3,0,29},
            '{7,7,0,57}, '{10,2,0,0}, '{10,5,0,46}, '{14,6,0,0}, '{14,7,0,64},
            '{0,0,1,1}, '{1,0,1,9}, '{1,1,1,2}, '{1,2,1,0}, '{7,0,1,57},
            '{7,3,1,36}, '{7,7,1,8}, '{10,4,1,53}, '{14,7,1,64}, '{14,0,1,0}};
    ifa.wr_en = 0;
    ifa.wr_row = '0;
    ifa.wr_data = '{default: '0};
    ifa.start = 0;
    #2;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    load_pattern();
    run_stream(-1, 0, -1, vcyc, dcyc);
    chk("basic_valid_cycles", vcyc, 15);
    chk("basic_done_cycle", dcyc, 16);
    check_table("basic");
    run_stream(5, 3, -1, vcyc, dcyc);
    chk("stall_valid_cycles", vcyc, 18);
    chk("stall_done_cycle", dcyc, 19);
    check_table("stall");
    run_stream(-1, 0, 2, vcyc, dcyc);
    check_table("midwrite");
    run_stream(-1, 0, -1, vcyc, dcyc);
    check_table("replay");
    @(posedge clk);
    #1;
    foreach (d[i]) d[i] = 8'sd50;
    ifa.wr_data = d;
    ifa.wr_row = 3'd0;
    ifa.wr_en = 1;
    ifa.start = 1;
    @(posedge clk);
    #1 ifa.wr_en = 0;
    ifa.start = 0;
    @(negedge clk);
    chk("startwr_busy", int'(ifa.busy) + int'(ifb.busy), 0);
    chk("startwr_valid", int'(ifa.out_valid), 0);
    @(posedge clk);
    #1;
    run_stream(-1, 0, -1, vcyc, dcyc);
    chk("startwr_A_s0_l0", cap_a[0][0], 50);
    chk("startwr_A_s7_l0", cap_a[7][0], 50);
    chk("startwr_A_s1_l1", cap_a[1][1], 9);
    chk("startwr_B_s7_l7", cap_b[7][7], 50);
    @(posedge clk);
    #1;
    d = '{default: '0};
    d[0] = -8'sd128;
    d[1] = 8'sd127;
    load_row(0, d);
    ifa.start = 1;
    @(posedge clk);
    #1 ifa.start = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("prereset_valid", int'(ifa.out_valid), 1);
    #2 rst_n = 0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    run_stream(-1, 0, -1, vcyc, dcyc);
    chk("zero_valid_cycles", vcyc, 15);
    nz = 0;
    for (int i = 0; i < 15; i++)
      for (int l = 0; l < 8; l++) nz += (cap_a[i][l] != 0) + (cap_b[i][l] != 0);
    chk("zero_stream_nonzero", nz, 0);
    @(posedge clk);
    #1;
    load_row(0, d);
    run_stream(-1, 0, -1, vcyc, dcyc);
    chk("sign_A_s0_l0", cap_a[0][0], -128);
    chk("sign_A_s1_l0", cap_a[1][0], 127);
    chk("sign_B_s0_l0", cap_b[0][0], -128);
    chk("sign_B_s1_l1", cap_b[1][1], 127);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Buffers one DIM x DIM operand matrix and streams it into one edge of the systolic MAC array as a diagonal wavefront. Lane r is delayed by r cycles, so element (r,c) enters lane r at step r+c. One instance drives the A (row) inputs and a second, with TRANSPOSE=1, drives the B (column) inputs. Sits directly upstream of the array and shares its clk/rst_n/en.

Parameters:
BITS_AB, 8, signed element width (matches the array's A/B width)
DIM, 8, matrix dimension and number of output lanes
TRANSPOSE, 0, 0: lane r streams row r (A side); 1: lane r streams column r (B side)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
en  input  1  advance enable; 0 stalls streaming (same en as the array)
wr_en  input  1  load one matrix row into the buffer
wr_row  input  $clog2(DIM)  row index for wr_en
wr_data  input  signed [BITS_AB-1:0] x DIM  row contents; element c goes to M[wr_row][c]
start  input  1  begin streaming the buffered matrix
busy  output  1  high while in STREAM
out_valid  output  1  out_data holds a valid wavefront step
out_data  output  signed [BITS_AB-1:0] x DIM  skewed lane values, to the array's A or B inputs
done  output  1  one-cycle pulse after the final step

Behaviour:
- Clock and reset: clk is the only clock. rst_n is asynchronous and active-low.
- Reset state: all M entries 0, state IDLE, step counter 0, out_data all 0, out_valid 0, busy 0, done 0. Reset mid-stream aborts immediately to this state, and the buffer contents are lost.
- Storage: DIM x DIM registers, M[row][col].
- Loading: wr_en in IDLE writes wr_data into M[wr_row] at the clock edge and is independent of en. wr_en in STREAM is ignored and the buffer is unchanged.
- Step t value, t = 0 .. 2*DIM-2:
  - TRANSPOSE=0: lane r = M[r][t-r] if 0 <= t-r < DIM, else 0.
  - TRANSPOSE=1: lane r = M[t-r][r] under the same bounds, else 0.
- Outputs are all registered.
- FSM IDLE:
  - start=1 and wr_en=0 at an edge: out_data <= step 0, out_valid <= 1, busy <= 1, t <= 1, go to STREAM. en is not required for start.
  - start=1 and wr_en=1 in the same cycle: the write commits, start is ignored, and the FSM stays in IDLE.
- FSM STREAM, edge with en=1:
  - t <= 2*DIM-2: out_data <= step t, t <= t+1.
  - t == 2*DIM-1: out_data <= 0, out_valid <= 0, busy <= 0, done <= 1, t <= 0, go to IDLE.
- FSM STREAM, edge with en=0: all state and outputs hold (out_valid stays 1, out_data unchanged); start is ignored.
- done is high for exactly one cycle. It is independent of en once asserted and clears on the next edge.
- Latency: step 0 appears the cycle after start is accepted. out_valid is high for exactly 2*DIM-1 en=1 cycles. done asserts on the (2*DIM-1)th en=1 edge after start, counting the first stepping edge as 1.
- The buffer is not cleared by streaming. A second start replays the same matrix.
- Values pass through unmodified: no width change and no saturation. The counter width is $clog2(2*DIM).

Decomposition:
- Shared package (alongside the array's parameters): default BITS_AB/DIM constants, the FSM state enum (IDLE, STREAM), and a typedef for a DIM-wide signed element vector.
- Optional sub-module systolic_skew_lane: a pure per-lane index/bound/select mux, instanced DIM times by generate. Storage, FSM and counter stay in the top.

Test Plan:
1. Basic A stream: DIM=8, TRANSPOSE=0, load M[r][c]=8r+c+1, en=1, pulse start.
   - Step 0: out_data[0]=1, lanes 1..7 = 0.
   - Step 7: out[0]=8, out[3]=29, out[7]=57.
   - Step 14: only out[7]=64.
   - done pulses on the edge after step 14; out_valid is high for exactly 15 cycles.
2. B stream: same matrix, TRANSPOSE=1.
   - Step 1: out[0]=9, out[1]=2, others 0.
   - Step 14: out[7]=64.
3. Stall: assert en=0 for 3 cycles at step 5. out_data and out_valid hold the step 5 values, and the total stream stretches to 18 cycles with the step order unchanged.
4. Ignored inputs:
   - wr_en with new data mid-stream: the stream still shows the old values, and a second start replays the old matrix.
   - start+wr_en together in IDLE: busy stays 0 and the row is updated.
5. Reset and sign: load values including -128 and 127, start, then drop rst_n at step 6.
   - During reset: out_data=0 and out_valid/busy/done=0 asynchronously.
   - After reset a new start streams all zeros; a reload and restart passes -128 unchanged.
